spike_count_classifier: RTL and testbench

- Output-side decoding stage directly downstream of the output spiking layer (OUTPUT_SIZE neurons).
- Accumulates per-neuron spike counts over one rate-coding window of SPIKE_WINDOW timesteps.
- After the window closes, performs a sequential argmax over the counts and presents the winning class index with a one-cycle valid pulse.
- Sizing constants come from network_pkg.

---
 rtl/network_pkg.sv | 18 +
 rtl/spike_count_classifier_bank.sv | 37 +++
 rtl/spike_count_classifier.sv | 142 ++++++++++++++
 tb/tb_spike_count_classifier.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/network_pkg.sv
// Shared sizing constants and types for the spiking network datapath.
// Classifier state encoding and derived widths live here too.
package network_pkg;

  localparam int OUTPUT_SIZE  = 16;
  localparam int SPIKE_WINDOW = 16;

  localparam int CLS_CNT_W = $clog2(SPIKE_WINDOW + 1);
  localparam int CLS_IDX_W = $clog2(OUTPUT_SIZE);

  typedef enum logic [1:0] {
    CLS_IDLE,
    CLS_COUNT,
    CLS_ARGMAX,
    CLS_DONE
  } cls_state_t;

endpackage

// File: rtl/spike_count_classifier_bank.sv
// Bank of per-neuron saturating spike counters.
// The scan index selects one count on the read port.
module spike_counter_bank #(
  parameter int N_OUT = 16,
  parameter int CNT_W = 5,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc_en,
  input  logic [N_OUT-1:0] inc_vec,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt [N_OUT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_OUT; i++)
        cnt[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < N_OUT; i++)
        cnt[i] <= '0;
    end else if (inc_en) begin
      for (int i = 0; i < N_OUT; i++)
        if (inc_vec[i] && cnt[i] != CNT_MAX)
          cnt[i] <= cnt[i] + 1'b1;
    end
  end

  assign rd_cnt = cnt[rd_idx];

endmodule

// File: rtl/spike_count_classifier.sv
// Rate-coded output decoder: counts spikes per neuron over a window,
// then scans the counts sequentially for the winning class.
module spike_count_classifier
  import network_pkg::*;
#(
  parameter int N_OUT  = OUTPUT_SIZE,
  parameter int WINDOW = SPIKE_WINDOW,
  parameter int CNT_W  = $clog2(WINDOW + 1),
  parameter int IDX_W  = $clog2(N_OUT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             spike_valid,
  input  logic [N_OUT-1:0] spike_in,
  output logic             busy,
  output logic             result_valid,
  output logic [IDX_W-1:0] class_idx,
  output logic [CNT_W-1:0] class_count,
  output logic             no_spike
);

  localparam int TS_W = $clog2(WINDOW + 1);
  localparam logic [TS_W-1:0] TS_LAST = TS_W'(WINDOW - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_OUT - 1);

  cls_state_t state, state_nxt;

  logic [TS_W-1:0]  ts_cnt, ts_nxt;
  logic [IDX_W-1:0] scan_idx, scan_nxt;
  logic [IDX_W-1:0] best_idx, best_idx_nxt;
  logic [CNT_W-1:0] best_cnt, best_cnt_nxt;
  logic [CNT_W-1:0] rd_cnt;
  logic             clear;
  logic             inc_en;
  logic             accept;

  assign accept = !abort && state == CLS_IDLE && start;

  spike_counter_bank #(
    .N_OUT (N_OUT),
    .CNT_W (CNT_W),
    .IDX_W (IDX_W)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .inc_en  (inc_en),
    .inc_vec (spike_in),
    .rd_idx  (scan_idx),
    .rd_cnt  (rd_cnt)
  );

  always_comb begin
    state_nxt    = state;
    ts_nxt       = ts_cnt;
    scan_nxt     = scan_idx;
    best_idx_nxt = best_idx;
    best_cnt_nxt = best_cnt;
    clear        = 1'b0;
    inc_en       = 1'b0;
    if (abort) begin
      state_nxt = CLS_IDLE;
      ts_nxt    = '0;
      clear     = 1'b1;
    end else begin
      unique case (state)
        CLS_IDLE: begin
          if (start) begin
            state_nxt = CLS_COUNT;
            ts_nxt    = '0;
            clear     = 1'b1;
          end
        end
        CLS_COUNT: begin
          if (spike_valid) begin
            inc_en = 1'b1;
            ts_nxt = ts_cnt + 1'b1;
            if (ts_cnt == TS_LAST) begin
              state_nxt    = CLS_ARGMAX;
              scan_nxt     = '0;
              best_idx_nxt = '0;
              best_cnt_nxt = '0;
            end
          end
        end
        CLS_ARGMAX: begin
          // strict compare keeps the lower index on ties
          if (rd_cnt > best_cnt) begin
            best_idx_nxt = scan_idx;
            best_cnt_nxt = rd_cnt;
          end
          scan_nxt = scan_idx + 1'b1;
          if (scan_idx == IDX_LAST)
            state_nxt = CLS_DONE;
        end
        CLS_DONE: state_nxt = CLS_IDLE;
        default:  state_nxt = CLS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CLS_IDLE;
      ts_cnt   <= '0;
      scan_idx <= '0;
      best_idx <= '0;
      best_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ts_cnt   <= ts_nxt;
      scan_idx <= scan_nxt;
      best_idx <= best_idx_nxt;
      best_cnt <= best_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy         <= 1'b0;
      result_valid <= 1'b0;
      class_idx    <= '0;
      class_count  <= '0;
      no_spike     <= 1'b0;
    end else begin
      busy <= state_nxt == CLS_COUNT || state_nxt == CLS_ARGMAX;
      result_valid <= state_nxt == CLS_DONE;
      if (accept) begin
        class_idx   <= '0;
        class_count <= '0;
        no_spike    <= 1'b0;
      end else if (state_nxt == CLS_DONE) begin
        class_idx   <= best_idx_nxt;
        class_count <= best_cnt_nxt;
        no_spike    <= best_cnt_nxt == '0;
      end
    end
  end

endmodule

// File: tb/tb_spike_count_classifier.sv
// Directed bench for spike_count_classifier with a window-level
// reference model checked against the outputs every cycle.
module tb_spike_count_classifier;
  import network_pkg::*;

  localparam int N = 16;
  localparam int LAT = N + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        spike_valid = 1'b0;
  logic [15:0] spike_in = '0;
  logic        busy;
  logic        result_valid;
  logic [3:0]  class_idx;
  logic [4:0]  class_count;
  logic        no_spike;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  spike_count_classifier dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .spike_valid  (spike_valid),
    .spike_in     (spike_in),
    .busy         (busy),
    .result_valid (result_valid),
    .class_idx    (class_idx),
    .class_count  (class_count),
    .no_spike     (no_spike)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // reference: mode 0 idle, 1 collecting beats, 2 scanning, 3 result
  int   m_mode = 0;
  int   m_beats = 0;
  int   m_wait = 0;
  int   m_cnt [N];
  logic e_busy = 0;
  logic e_valid = 0;
  int   e_idx = 0;
  int   e_cnt = 0;
  logic e_ns = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_beats = 0; m_wait = 0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
      e_busy = 0; e_valid = 0; e_idx = 0; e_cnt = 0; e_ns = 0;
    end else begin
      e_valid = 0;
      if (abort) begin
        m_mode = 0;
        e_busy = 0;
        foreach (m_cnt[i]) m_cnt[i] = 0;
      end else begin
        case (m_mode)
          0: if (start) begin
            m_mode = 1; m_beats = 0;
            foreach (m_cnt[i]) m_cnt[i] = 0;
            e_idx = 0; e_cnt = 0; e_ns = 0; e_busy = 1;
          end
          1: if (spike_valid) begin
            for (int i = 0; i < N; i++)
              if (spike_in[i] && m_cnt[i] < 31) m_cnt[i]++;
            m_beats++;
            if (m_beats == 16) begin
              m_mode = 2; m_wait = N;
            end
          end
          2: begin
            m_wait--;
            if (m_wait == 0) begin
              m_mode = 3; e_busy = 0; e_valid = 1;
              e_idx = 0; e_cnt = 0;
              for (int i = 0; i < N; i++)
                if (m_cnt[i] > e_cnt) begin
                  e_idx = i; e_cnt = m_cnt[i];
                end
              e_ns = (e_cnt == 0);
            end
          end
          default: m_mode = 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, e_busy);
    chk("result_valid", result_valid, e_valid);
    chk("class_idx", class_idx, e_idx);
    chk("class_count", class_count, e_cnt);
    chk("no_spike", no_spike, e_ns);
    if (result_valid) pulses++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic beat(input logic [15:0] v);
    spike_valid = 1'b1;
    spike_in = v;
    step(1);
    spike_valid = 1'b0;
    spike_in = '0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (result_valid) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) begin
      errors++;
      $display("FAIL timeout: got no result_valid expected one");
    end
  endtask

  task automatic check_result(input string tag, input int lat,
                              input int idx, input int cnt,
                              input int ns);
    chk({tag, "_lat"}, lat, LAT);
    chk({tag, "_idx"}, class_idx, idx);
    chk({tag, "_cnt"}, class_count, cnt);
    chk({tag, "_nospike"}, no_spike, ns);
  endtask

  int lat;
  int p0;
  logic [15:0] v;

  initial begin
    step(3);
    chk("rst_busy", busy, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_idx", class_idx, 0);
    chk("rst_nospike", no_spike, 0);
    rst_n = 1'b1;
    step(2);

    // dominant neuron
    do_start();
    for (int i = 0; i < 16; i++) beat(16'h0008);
    wait_result(lat);
    check_result("dom", lat, 3, 16, 0);
    step(3);
    chk("dom_hold", class_idx, 3);

    // tie between 5 and 9, 12 one short
    do_start();
    for (int i = 0; i < 16; i++) begin
      if (i < 8) v = 16'h0020 | (i < 7 ? 16'h1000 : 16'h0000);
      else       v = 16'h0200;
      beat(v);
    end
    wait_result(lat);
    check_result("tie", lat, 5, 8, 0);
    step(2);

    // silent window
    do_start();
    for (int i = 0; i < 16; i++) beat(16'h0000);
    wait_result(lat);
    check_result("silent", lat, 0, 0, 1);
    step(2);

    // gapped beats, stray valid with start and during scan
    start = 1'b1;
    spike_valid = 1'b1;
    spike_in = 16'h8000;
    step(1);
    start = 1'b0;
    spike_valid = 1'b0;
    spike_in = '0;
    for (int i = 0; i < 16; i++) begin
      step($urandom_range(0, 3));
      beat(16'h8000);
    end
    spike_valid = 1'b1;
    spike_in = 16'hFFFF;
    start = 1'b1;
    wait_result(lat);
    spike_valid = 1'b0;
    spike_in = '0;
    start = 1'b0;
    check_result("gap", lat, 15, 16, 0);
    step(2);

    // start during count must not stretch or restart the window
    p0 = pulses;
    do_start();
    for (int i = 0; i < 16; i++) begin
      start = (i >= 4 && i <= 6);
      beat(16'h0400);
    end
    start = 1'b0;
    wait_result(lat);
    check_result("restart", lat, 10, 16, 0);
    step(25);
    chk("restart_pulses", pulses - p0, 1);

    // abort after beat 7
    p0 = pulses;
    do_start();
    for (int i = 0; i < 7; i++) beat(16'h0001);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_idx", class_idx, 0);
    step(30);
    chk("abort_pulses", pulses - p0, 0);

    // async reset during scan, then a clean window
    do_start();
    for (int i = 0; i < 16; i++) beat(16'h0002);
    step(5);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", result_valid, 0);
    chk("arst_idx", class_idx, 0);
    chk("arst_cnt", class_count, 0);
    chk("arst_nospike", no_spike, 0);
    step(2);
    rst_n = 1'b1;
    step(1);
    do_start();
    for (int i = 0; i < 16; i++) beat(16'h0040);
    wait_result(lat);
    check_result("post_rst", lat, 6, 16, 0);
    step(3);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
